pacman_input_scheduler: RTL and testbench
=========================================

# pacman_input_scheduler

Turns the raw USB HID keycode from the SoC's `keycode_export` into registered Pac-Man movement commands for the game logic. It holds a short-lived buffered turn request and commits it only on tile-aligned `tick` pulses when the maze reports that direction open. It also runs the game-state machine (IDLE/RUN/PAUSED) and detects key edges for pause and restart. It sits between the `lab62soc` keycode PIO and the sprite-motion logic.

## Interface
- `HOLD_TICKS`, 8: number of `tick`s a buffered turn stays valid; range 1–255.
- `clk_clk` in 1: system clock, 50 MHz.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `keycode` in 8: HID keycode from the SoC; 0x00 means no key.
- `tick` in 1: single-cycle pulse; Pac-Man is tile-aligned.
- `turn_ok` in 4: open directions at the current tile, indexed by direction code.
- `dir` out 2: committed direction; 0=RIGHT, 1=UP, 2=LEFT, 3=DOWN.
- `moving` out 1: Pac-Man advances this tile.
- `running` out 1: state is RUN.
- `paused` out 1: state is PAUSED.
- `restart` out 1: one-cycle pulse when the game (re)starts.
- `pend_valid` out 1: a buffered turn exists (LED debug).
- `pend_dir` out 2: the buffered direction.

## Operation
- **Key capture.** `keycode` is registered once into `kc_q`; `kc_prev` holds the previous `kc_q`. Decoding uses `kc_q` only.
- **Key map.**
  - W=0x1A → UP, A=0x04 → LEFT, S=0x16 → DOWN, D=0x07 → RIGHT.
  - P=0x13 → pause.
  - Enter=0x28 → start.
  - Any other value is ignored.
- **Edge rule.** Pause and start act only when `kc_q` equals the key and `kc_prev` does not. Direction keys act every cycle they are held.
- **IDLE.**
  - Outputs low, `dir`=LEFT.
  - A start edge sets `dir`=LEFT, clears the pending turn, pulses `restart`, and enters RUN.
- **RUN.**
  - A start edge restarts: same actions as in IDLE, then stays in RUN.
  - A pause edge enters PAUSED.
- **PAUSED.**
  - A pause edge returns to RUN.
  - A start edge restarts into RUN.
  - `tick`, direction keys and the hold counter are frozen.
- **Direction key in RUN, key = opposite of `dir`** (`dir` ^ 2): commits `dir` on the next cycle without waiting for `tick` and clears the pending turn. `moving` is unchanged.
- **Direction key in RUN, key = `dir`:** ignored.
- **Any other direction key in RUN:** sets `pend_valid`=1 and `pend_dir`=key, and reloads `hold_cnt`=HOLD_TICKS. A held key reloads the counter every cycle.
- **On `tick` in RUN**, evaluated using the register values from before this cycle's key update:
  - If `pend_valid` and `turn_ok[pend_dir]`: `dir`←`pend_dir`, clear the pending turn, `moving`←1.
  - Otherwise `moving`←`turn_ok[dir]`. If `pend_valid`, decrement `hold_cnt`; when it reaches 0, clear `pend_valid`.
- **Tick and key in the same cycle:** the tick decision uses the old pending state. The new key's load then overrides the pending result, so the key wins for the next tick.
- **Reset values:** all state returns to IDLE, `dir`=LEFT, and every other output and register is 0.

## Timing
- Key-to-decode latency is 1 cycle (`kc_q`). A reversal is visible on `dir` 2 cycles after `keycode` changes.
- A turn commits in the cycle after the qualifying `tick`. `dir` and `moving` update together.
- `restart` is high for exactly 1 cycle, 2 cycles after the Enter keycode appears.
- `running`, `paused` and `moving` are registered; no output is combinational from inputs.
- `hold_cnt` width is $clog2(HOLD_TICKS+1). It never underflows: a decrement from 1 clears `pend_valid` and leaves the counter at 0.
- Reset asserted mid-turn or mid-pause returns everything to reset values immediately. No `restart` pulse is issued on reset release.

## Configuration
- `PACMAN_ARROW_KEYS_EN` defined: also decode the arrow keys Right=0x4F, Left=0x50, Down=0x51, Up=0x52, with the same behaviour as WASD.
- Macro undefined: arrow codes are treated as no key.

## Structure
- Package `pacman_input_pkg` holds:
  - `dir_t` (2-bit enum RIGHT/UP/LEFT/DOWN);
  - `game_state_t` (IDLE/RUN/PAUSED);
  - the keycode constants `KC_W`, `KC_A`, `KC_S`, `KC_D`, `KC_P`, `KC_ENTER`, `KC_RIGHT`, `KC_LEFT`, `KC_DOWN`, `KC_UP`;
  - function `opposite(dir_t)`.
- Sub-module `keycode_decoder` is purely combinational. It maps `kc_q` to {`dir_valid`, `dir_key`, `is_pause`, `is_start`} and contains the `PACMAN_ARROW_KEYS_EN` guard.

## Test plan
- **Reset and start:** reset, `keycode`=0x28 for 3 cycles → `restart` pulses once, `running`=1, `dir`=2. Holding Enter produces no second pulse.
- **Buffered turn:** RUN, `dir`=LEFT, key 0x1A (W) then 0x00, `turn_ok`=4'b0100.
  - 2 ticks → `dir` stays 2, `pend_valid`=1.
  - Then `turn_ok`=4'b0110 and a tick → `dir`=1, `pend_valid`=0.
- **Expiry:** HOLD_TICKS=8, key W released, `turn_ok`=4'b0100 → after the 8th tick `pend_valid`=0, `dir`=2.
- **Reversal and wall:**
  - `dir`=LEFT, key D → `dir`=0 within 2 cycles, no tick needed.
  - `turn_ok`=0 and a tick → `moving`=0.
- **Pause:**
  - Key P held 5 cycles → `paused`=1 once; ticks and W are ignored and `hold_cnt` is unchanged.
  - Release P, press P again → `running`=1.
- **Config and reset:**
  - With `PACMAN_ARROW_KEYS_EN`, key 0x52 → `pend_dir`=1. Without it → `pend_valid` stays 0.
  - Asserting `reset_reset_n`=0 mid-PAUSED → IDLE, `dir`=2, all flags 0.

Source files
------------

// File: rtl/pacman_input_scheduler_pkg.sv
// Shared types, keycode constants and direction helper for the Pac-Man input scheduler.
package pacman_input_pkg;

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        UP    = 2'd1,
        LEFT  = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } game_state_t;

    typedef struct packed {
        logic dir_valid;
        dir_t dir_key;
        logic is_pause;
        logic is_start;
    } key_dec_t;

    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_P     = 8'h13;
    localparam logic [7:0] KC_ENTER = 8'h28;
    localparam logic [7:0] KC_RIGHT = 8'h4F;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_DOWN  = 8'h51;
    localparam logic [7:0] KC_UP    = 8'h52;

    // Direction codes are arranged so the reverse is bit 1 flipped.
    function automatic dir_t opposite(dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

endpackage

// File: rtl/pacman_input_scheduler_if.sv
// Keycode/tick/maze inputs and movement/game-state outputs of the input scheduler.
interface pacman_input_scheduler_if;
    logic [7:0] keycode;
    logic       tick;
    logic [3:0] turn_ok;
    logic [1:0] dir;
    logic       moving;
    logic       running;
    logic       paused;
    logic       restart;
    logic       pend_valid;
    logic [1:0] pend_dir;

    modport master (
        output keycode, tick, turn_ok,
        input  dir, moving, running, paused, restart, pend_valid, pend_dir
    );

    modport slave (
        input  keycode, tick, turn_ok,
        output dir, moving, running, paused, restart, pend_valid, pend_dir
    );
endinterface

// File: rtl/pacman_input_scheduler_keycode_decoder.sv
// Combinational HID keycode decoder. Arrow keys decode only when
// PACMAN_ARROW_KEYS_EN is defined.
module keycode_decoder
    import pacman_input_pkg::*;
(
    input  logic [7:0] i_kc,
    output key_dec_t   o_dec
);
`ifdef PACMAN_ARROW_KEYS_EN
    localparam bit ARROW_EN = 1'b1;
`else
    localparam bit ARROW_EN = 1'b0;
`endif

    always_comb begin
        o_dec         = '0;
        o_dec.dir_key = RIGHT;
        case (i_kc)
            KC_W:     begin o_dec.dir_valid = 1'b1; o_dec.dir_key = UP;    end
            KC_A:     begin o_dec.dir_valid = 1'b1; o_dec.dir_key = LEFT;  end
            KC_S:     begin o_dec.dir_valid = 1'b1; o_dec.dir_key = DOWN;  end
            KC_D:     begin o_dec.dir_valid = 1'b1; o_dec.dir_key = RIGHT; end
            KC_RIGHT: begin o_dec.dir_valid = ARROW_EN; o_dec.dir_key = RIGHT; end
            KC_LEFT:  begin o_dec.dir_valid = ARROW_EN; o_dec.dir_key = LEFT;  end
            KC_DOWN:  begin o_dec.dir_valid = ARROW_EN; o_dec.dir_key = DOWN;  end
            KC_UP:    begin o_dec.dir_valid = ARROW_EN; o_dec.dir_key = UP;    end
            KC_P:     o_dec.is_pause = 1'b1;
            KC_ENTER: o_dec.is_start = 1'b1;
            default:  ;
        endcase
    end
endmodule

// File: rtl/pacman_input_scheduler.sv
// Pac-Man input scheduler: keycode capture, game-state FSM and tick-aligned
// buffered turns. Optional arrow-key decode via PACMAN_ARROW_KEYS_EN.
module pacman_input_scheduler
    import pacman_input_pkg::*;
#(
    parameter int HOLD_TICKS = 8
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    pacman_input_scheduler_if.slave   bus
);
    localparam int              CW        = $clog2(HOLD_TICKS + 1);
    localparam logic [CW-1:0]   HOLD_INIT = CW'(HOLD_TICKS);

    logic [7:0]    r_kc_q, r_kc_prev;
    game_state_t   r_state;
    dir_t          r_dir, r_pend_dir;
    logic          r_moving, r_restart, r_pend_valid;
    logic [CW-1:0] r_hold_cnt;

    key_dec_t w_dec;
    logic     w_start_edge, w_pause_edge;

    keycode_decoder u_dec (
        .i_kc  (r_kc_q),
        .o_dec (w_dec)
    );

    assign w_start_edge = w_dec.is_start && (r_kc_prev != KC_ENTER);
    assign w_pause_edge = w_dec.is_pause && (r_kc_prev != KC_P);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_kc_q       <= '0;
            r_kc_prev    <= '0;
            r_state      <= IDLE;
            r_dir        <= LEFT;
            r_pend_dir   <= RIGHT;
            r_moving     <= 1'b0;
            r_restart    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_hold_cnt   <= '0;
        end else begin
            r_kc_q    <= bus.keycode;
            r_kc_prev <= r_kc_q;
            r_restart <= 1'b0;
            if (w_start_edge) begin
                // Start behaves identically from every state.
                r_state      <= RUN;
                r_dir        <= LEFT;
                r_pend_valid <= 1'b0;
                r_moving     <= 1'b0;
                r_restart    <= 1'b1;
            end else begin
                case (r_state)
                    RUN: begin
                        if (w_pause_edge) begin
                            r_state <= PAUSED;
                        end else begin
                            if (bus.tick) begin
                                if (r_pend_valid && bus.turn_ok[r_pend_dir]) begin
                                    r_dir        <= r_pend_dir;
                                    r_pend_valid <= 1'b0;
                                    r_moving     <= 1'b1;
                                end else begin
                                    r_moving <= bus.turn_ok[r_dir];
                                    if (r_pend_valid) begin
                                        if (r_hold_cnt <= CW'(1)) begin
                                            r_hold_cnt   <= '0;
                                            r_pend_valid <= 1'b0;
                                        end else begin
                                            r_hold_cnt <= r_hold_cnt - CW'(1);
                                        end
                                    end
                                end
                            end
                            // Key handling comes last so a fresh key overrides the tick result.
                            if (w_dec.dir_valid) begin
                                if (w_dec.dir_key == opposite(r_dir)) begin
                                    r_dir        <= w_dec.dir_key;
                                    r_pend_valid <= 1'b0;
                                end else if (w_dec.dir_key != r_dir) begin
                                    r_pend_valid <= 1'b1;
                                    r_pend_dir   <= w_dec.dir_key;
                                    r_hold_cnt   <= HOLD_INIT;
                                end
                            end
                        end
                    end
                    PAUSED: if (w_pause_edge) r_state <= RUN;
                    default: ;
                endcase
            end
        end
    end

    assign bus.dir        = r_dir;
    assign bus.moving     = r_moving;
    assign bus.running    = (r_state == RUN);
    assign bus.paused     = (r_state == PAUSED);
    assign bus.restart    = r_restart;
    assign bus.pend_valid = r_pend_valid;
    assign bus.pend_dir   = r_pend_dir;
endmodule

// File: tb/tb_pacman_input_scheduler.sv
// Scenario bench for pacman_input_scheduler: expected output vectors are queued
// when stimulus is applied and popped when the response is sampled.
module tb_pacman_input_scheduler;
    logic clk_clk = 1'b0;
    logic reset_reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [8:0] sb[$];
    logic [8:0] e;

    pacman_input_scheduler_if bus ();

    pacman_input_scheduler #(.HOLD_TICKS(8)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bus           (bus)
    );

    always #5 clk_clk = ~clk_clk;

`ifdef PACMAN_ARROW_KEYS_EN
    localparam bit ARROW = 1'b1;
`else
    localparam bit ARROW = 1'b0;
`endif

    // {running, paused, moving, restart, pend_valid, pend_dir, dir}
    function automatic logic [8:0] pk(bit r, bit p, bit m, bit rs, bit pv, logic [1:0] pd, logic [1:0] d);
        return {r, p, m, rs, pv, pd, d};
    endfunction

    function automatic logic [8:0] obs();
        return {bus.running, bus.paused, bus.moving, bus.restart, bus.pend_valid, bus.pend_dir, bus.dir};
    endfunction

    task automatic cyc(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.keycode = 8'h00; bus.tick = 1'b0; bus.turn_ok = 4'b0000;
        sb.push_back(pk(0,0,0,0,0,2'd0,2'd2));
        cyc(2);
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_state: got %b want %b", obs(), e); end
        reset_reset_n = 1'b1;
    endtask

    task automatic test_start();
        bus.keycode = 8'h28;
        sb.push_back(pk(0,0,0,0,0,2'd0,2'd2));
        sb.push_back(pk(1,0,0,1,0,2'd0,2'd2));
        sb.push_back(pk(1,0,0,0,0,2'd0,2'd2));
        for (int i = 0; i < 3; i++) begin
            cyc();
            e = sb.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL start_c%0d: got %b want %b", i + 1, obs(), e); end
        end
        for (int i = 0; i < 4; i++) begin
            sb.push_back(pk(1,0,0,0,0,2'd0,2'd2));
            cyc();
            e = sb.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL enter_held_c%0d: got %b want %b", i, obs(), e); end
        end
        bus.keycode = 8'h00; cyc(2);
    endtask

    task automatic test_buffered_turn();
        bus.turn_ok = 4'b0100;
        bus.keycode = 8'h1A; cyc(2);
        sb.push_back(pk(1,0,0,0,1,2'd1,2'd2));
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL turn_load: got %b want %b", obs(), e); end
        bus.keycode = 8'h00; cyc(2);
        sb.push_back(pk(1,0,1,0,1,2'd1,2'd2));
        ticks(2);
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL turn_blocked: got %b want %b", obs(), e); end
        bus.turn_ok = 4'b0110;
        sb.push_back(pk(1,0,1,0,0,2'd1,2'd1));
        ticks(1);
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL turn_commit: got %b want %b", obs(), e); end
    endtask

    task automatic test_expiry();
        bus.keycode = 8'h28;
        sb.push_back(pk(1,0,0,1,0,2'd1,2'd2));
        cyc(2);
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL restart_in_run: got %b want %b", obs(), e); end
        bus.keycode = 8'h00; cyc();
        bus.turn_ok = 4'b0100;
        bus.keycode = 8'h1A; cyc(2);
        bus.keycode = 8'h00; cyc(2);
        sb.push_back(pk(1,0,1,0,1,2'd1,2'd2));
        ticks(7);
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL expiry_tick7: got %b want %b", obs(), e); end
        sb.push_back(pk(1,0,1,0,0,2'd1,2'd2));
        ticks(1);
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL expiry_tick8: got %b want %b", obs(), e); end
    endtask

    task automatic test_reversal_wall();
        bus.keycode = 8'h07;
        sb.push_back(pk(1,0,1,0,0,2'd1,2'd2));
        sb.push_back(pk(1,0,1,0,0,2'd1,2'd0));
        for (int i = 0; i < 2; i++) begin
            cyc();
            e = sb.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL reversal_c%0d: got %b want %b", i + 1, obs(), e); end
        end
        bus.keycode = 8'h00; cyc(2);
        sb.push_back(pk(1,0,1,0,0,2'd1,2'd0));
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL same_dir_ignored: got %b want %b", obs(), e); end
        bus.turn_ok = 4'b0000;
        sb.push_back(pk(1,0,0,0,0,2'd1,2'd0));
        ticks(1);
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL wall_stop: got %b want %b", obs(), e); end
    endtask

    task automatic test_pause();
        bus.keycode = 8'h1A; cyc(2);
        bus.keycode = 8'h00; cyc(2);
        ticks(3);
        sb.push_back(pk(1,0,0,0,1,2'd1,2'd0));
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL pre_pause: got %b want %b", obs(), e); end
        bus.keycode = 8'h13; cyc(2);
        sb.push_back(pk(0,1,0,0,1,2'd1,2'd0));
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL pause_enter: got %b want %b", obs(), e); end
        bus.tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(pk(0,1,0,0,1,2'd1,2'd0));
            cyc();
            e = sb.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL pause_held_c%0d: got %b want %b", i, obs(), e); end
        end
        bus.keycode = 8'h1A; cyc(3);
        bus.tick = 1'b0; bus.keycode = 8'h00; cyc(2);
        sb.push_back(pk(0,1,0,0,1,2'd1,2'd0));
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL pause_frozen: got %b want %b", obs(), e); end
        bus.keycode = 8'h13; cyc(2);
        sb.push_back(pk(1,0,0,0,1,2'd1,2'd0));
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL pause_resume: got %b want %b", obs(), e); end
        bus.keycode = 8'h00; cyc(2);
        // Three ticks were spent before the pause, so five remain.
        sb.push_back(pk(1,0,0,0,1,2'd1,2'd0));
        ticks(4);
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL hold_kept: got %b want %b", obs(), e); end
        sb.push_back(pk(1,0,0,0,0,2'd1,2'd0));
        ticks(1);
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL hold_expire: got %b want %b", obs(), e); end
    endtask

    task automatic test_arrow_keys();
        bus.keycode = 8'h51; cyc(2);
        bus.keycode = 8'h00; cyc(2);
        sb.push_back(ARROW ? pk(1,0,0,0,1,2'd3,2'd0) : pk(1,0,0,0,0,2'd1,2'd0));
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL arrow_key: got %b want %b", obs(), e); end
    endtask

    task automatic test_reset_mid_pause();
        bus.keycode = 8'h13; cyc(2);
        sb.push_back(ARROW ? pk(0,1,0,0,1,2'd3,2'd0) : pk(0,1,0,0,0,2'd1,2'd0));
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL pause_before_reset: got %b want %b", obs(), e); end
        bus.keycode = 8'h00; cyc();
        #2 reset_reset_n = 1'b0;
        #1;
        sb.push_back(pk(0,0,0,0,0,2'd0,2'd2));
        e = sb.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL async_reset: got %b want %b", obs(), e); end
        cyc();
        reset_reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(pk(0,0,0,0,0,2'd0,2'd2));
            cyc();
            e = sb.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL post_reset_c%0d: got %b want %b", i, obs(), e); end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_buffered_turn();
        test_expiry();
        test_reversal_wall();
        test_pause();
        test_arrow_keys();
        test_reset_mid_pause();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
